// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - K-term signed fixed-point MAC neuron stage; NEURON_MAC_SAT_EN selects saturating arithmetic
module neuron_mac #(
    parameter int N  = 2,
    parameter int QM = 6,
    parameter int QN = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [QM+QN-1:0]   x,
    input  logic signed [QM+QN-1:0]   w,
    input  logic signed [QM+QN-1:0]   bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [QM+QN+N-1:0] out
);

    localparam int D = QM + QN;
    localparam int W = QM + QN + N;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [N-1:0]         cnt_q;
    logic signed [W-1:0]  acc_q;
    logic signed [W-1:0]  acc_d;

    logic                 beat;
    logic                 last_beat;
    logic signed [2*D-1:0] prod_full;
    logic signed [2*D-1:0] prod_shift;
    logic signed [W-1:0]  bias_ext;
    logic signed [W-1:0]  base;

    assign beat      = in_valid && (state_q == ACCUM);
    assign last_beat = beat && (cnt_q == {N{1'b1}});

    // Arithmetic shift of the full-width product floors toward minus infinity.
    assign prod_full  = x * w;
    assign prod_shift = prod_full >>> QN;

    assign bias_ext = {{N{bias[D-1]}}, bias};
    // The first beat of each neuron starts from the bias instead of the old sum.
    assign base     = (cnt_q == '0) ? bias_ext : acc_q;

`ifdef NEURON_MAC_SAT_EN
    localparam logic signed [W-1:0]   acc_max  = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   acc_min  = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [2*D-1:0] prod_max = {{(2*D-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*D-1:0] prod_min = {{(2*D-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [W-1:0] p_use;
    logic signed [W:0]   sum_ext;

    always_comb begin
        p_use = prod_shift[W-1:0];
        if (prod_shift > prod_max) begin
            p_use = acc_max;
        end else if (prod_shift < prod_min) begin
            p_use = acc_min;
        end
    end

    // One guard bit exposes signed overflow: top two bits differ.
    assign sum_ext = {base[W-1], base} + {p_use[W-1], p_use};

    always_comb begin
        acc_d = sum_ext[W-1:0];
        if (sum_ext[W] != sum_ext[W-1]) begin
            acc_d = sum_ext[W] ? acc_min : acc_max;
        end
    end
`else
    logic signed [W-1:0] p_use;
    logic                unused_prod_hi;

    // Modulo 2^W: only the low W bits of the shifted product take part.
    assign p_use          = prod_shift[W-1:0];
    assign unused_prod_hi = ^prod_shift[2*D-1:W];
    assign acc_d          = base + p_use;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (beat) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_d;
        end
    end

    // Both handshake outputs come straight from the state register.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out       = acc_q;

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - directed self-checking bench for neuron_mac
module tb_neuron_mac;

    localparam int N  = 2;
    localparam int QM = 6;
    localparam int QN = 10;
    localparam int D  = QM + QN;
    localparam int W  = QM + QN + N;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [D-1:0] x;
    logic signed [D-1:0] w;
    logic signed [D-1:0] bias;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out;

    int vectors;
    int miscompares;

    neuron_mac #(.N(N), .QM(QM), .QN(QN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w         (w),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_beats(input int b, input int xv, input int wv, input int nb);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x        = D'(xv);
            w        = D'(wv);
            bias     = D'(b);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int exp);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, int'(out_valid), 1);
        check_eq({tag, "_out"}, int'(out), exp);
        check_eq({tag, "_in_ready_done"}, int'(in_ready), 0);
        if (out_ready) begin
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, "_valid_after"}, int'(out_valid), 0);
            check_eq({tag, "_in_ready_after"}, int'(in_ready), 1);
        end
    endtask

    initial begin
        int held;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        x           = '0;
        w           = '0;
        bias        = '0;
        #1;
        check_eq("reset_in_ready", int'(in_ready), 1);
        check_eq("reset_out_valid", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        drive_beats(0, 1024, 512, 4);
        expect_result("basic", 2048);

        drive_beats(512, -1024, 256, 4);
        expect_result("signed_bias", -512);

        drive_beats(0, -1, 1, 4);
        expect_result("trunc_neg", -4);

        drive_beats(0, 1, 1, 4);
        expect_result("trunc_pos", 0);

        // Backpressure: hold the result, offer pairs that must be ignored.
        out_ready = 1'b0;
        drive_beats(0, 1024, 1024, 4);
        check_eq("bp_valid", int'(out_valid), 1);
        held = int'(out);
        check_eq("bp_out", held, 4096);
        in_valid = 1'b1;
        x        = D'(1024);
        w        = D'(1024);
        bias     = D'(1024);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_hold_valid", int'(out_valid), 1);
            check_eq("bp_hold_out", int'(out), 4096);
            check_eq("bp_hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_release_in_ready", int'(in_ready), 1);
        check_eq("bp_release_valid", int'(out_valid), 0);

        drive_beats(0, 1024, 512, 4);
        expect_result("after_bp", 2048);

`ifdef NEURON_MAC_SAT_EN
        drive_beats(0, 32767, 32767, 4);
        expect_result("overflow", 131071);
`else
        drive_beats(0, 32767, 32767, 4);
        expect_result("overflow", -256);
`endif

        // Reset partway through a neuron discards the partial sum.
        drive_beats(512, 2048, 2048, 2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", int'(out_valid), 0);
        check_eq("mid_rst_in_ready", int'(in_ready), 1);
        #1 rst_n = 1'b1;
        drive_beats(0, 1024, 512, 4);
        expect_result("post_rst", 2048);

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        drive_beats(0, 1024, 512, 4);
        check_eq("done_rst_pre_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("done_rst_out_valid", int'(out_valid), 0);
        check_eq("done_rst_in_ready", int'(in_ready), 1);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        drive_beats(-1024, 1024, 1024, 4);
        expect_result("neg_bias", 3072);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Sequential multiply-accumulate neuron stage that sits directly upstream of the `Sigmoid` activation LUT. It accepts a stream of 2**N signed fixed-point (input, weight) pairs, one per handshake beat, and adds them to a bias. It presents the Q(QM+N).QN pre-activation sum on a width that feeds `Sigmoid.in` unmodified. The output is held under a valid/ready handshake until the consumer takes it.

## Interface
- `N`, 2: log2 of terms per neuron; K = 2**N pairs per result; also the number of accumulator guard bits.
- `QM`, 6: integer bits (including sign) of operands.
- `QN`, 10: fractional bits of operands and result.
- Derived: D = QM+QN (operand width), W = QM+QN+N (result width).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  pair on `x`/`w` is valid.
- `in_ready`  out  1  stage can accept a pair.
- `x`  in  D  signed activation, Q(QM).(QN).
- `w`  in  D  signed weight, Q(QM).(QN).
- `bias`  in  D  signed bias; sampled only on the first beat of a neuron.
- `out_valid`  out  1  `out` holds a completed sum.
- `out_ready`  in  1  consumer accepts `out`.
- `out`  out  W  signed sum, Q(QM+N).(QN); connects to `Sigmoid.in`.

## Operation
- States: ACCUM and DONE. Reset state is ACCUM.
- In ACCUM, `in_ready` = 1 and `out_valid` = 0. In DONE, `in_ready` = 0 and `out_valid` = 1.
- A beat is a rising edge with `in_valid && in_ready`.
- Product: p = (x*w) as a 2D-bit signed value, then arithmetic shift right by QN. This is floor truncation, with no rounding.
- The beat counter `cnt` (N bits) counts beats.
  - Beat with `cnt`==0: acc <= sext(bias) + p.
  - Any other beat: acc <= acc + p.
  - Each beat increments `cnt` modulo K.
- On the K-th beat (`cnt`==K-1), the state moves to DONE and `cnt` wraps to 0.
- In DONE, `out` = acc. The value is stable until the handshake completes.
- When `out_valid && out_ready` at an edge, the state returns to ACCUM.
- `out` is undefined-but-stable in ACCUM. The verifier checks `out` only when `out_valid` is high.
- Arithmetic is modulo 2^W by default: the product's low W bits are used, and sums wrap. `x`, `w` and `bias` are not checked for range.
- Reset, asynchronous: state=ACCUM, `cnt`=0, acc=0, `out_valid`=0, `in_ready`=1 one delta after `rst_n` falls. A partially accumulated neuron is discarded.
- `in_valid` arriving in DONE is ignored. The producer holds it until `in_ready` is high.

## Timing
- `out_valid` rises on the edge of the K-th accepted beat and is visible in the following cycle.
- Minimum neuron period is K+1 cycles: K beats plus at least one DONE cycle.
- DONE lasts exactly one cycle when `out_ready` is held high.
- All outputs are registered. There is no combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`.
- Gaps in `in_valid` stall accumulation without losing state.

## Configuration
- `NEURON_MAC_SAT_EN` defined: saturating arithmetic.
  - Each shifted product is clamped to [-2^(W-1), 2^(W-1)-1] before accumulation.
  - Each addition (bias+p, acc+p) is clamped to the same range.
- `NEURON_MAC_SAT_EN` undefined: wrap-around modulo 2^W as described in Operation.
- Handshake and timing are identical in both builds.

## Test plan
All scenarios use the defaults: K=4, 1.0 = 1024.

- Basic: bias=0, four beats x=1024 and w=512 -> `out_valid` in the cycle after beat 4, `out`=2048 (2.0).
- Signed with bias: bias=512, four beats x=-1024 and w=256 -> `out`=-512 (-0.5).
- Truncation: bias=0, four beats x=-1 and w=1 -> each p=-1, `out`=-4. Four beats x=1 and w=1 -> `out`=0.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles after completion -> `out_valid`=1 and `out` stable, `in_ready`=0.
  - Offer `in_valid`=1 during that window -> the offered pairs are not consumed.
  - Raise `out_ready` -> `in_ready`=1 on the next cycle.
- Overflow: bias=0, four beats x=32767 and w=32767 (p=1048512).
  - Without `NEURON_MAC_SAT_EN` -> `out`=-256.
  - With `NEURON_MAC_SAT_EN` -> `out`=131071.
- Reset mid-neuron: 2 beats accepted, then `rst_n` pulsed low asynchronously -> `out_valid`=0 and `in_ready`=1 immediately. Four fresh beats of the Basic scenario -> `out`=2048.
